fp_mul_seq: RTL and testbench



---
 rtl/fp_mul_seq_if.sv | 38 +++
 rtl/fp_mul_seq.sv | 156 +++++++++++++++
 tb/tb_fp_mul_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_seq_if.sv
// Operand/result bundle between an fp_mul_seq and the block that feeds it.
//
// Handshake: the master raises start for at least one cycle with A_FP/B_FP
// valid; the multiplier takes the request on the first rising edge where it
// is idle (busy=0) and ignores start at any other time. A request is never
// queued. busy stays high from the accepting edge until the result edge.
// done is a one-cycle pulse, and sign/exponent/mantissa are valid from that
// cycle. They hold until the next result or until reset.
//
// Signals:
//   start     master->slave  request
//   A_FP      master->slave  operand A, IEEE-754 single
//   B_FP      master->slave  operand B, IEEE-754 single
//   busy      slave->master  operation in flight
//   done      slave->master  result strobe (one cycle)
//   sign      slave->master  result sign
//   exponent  slave->master  result biased exponent
//   mantissa  slave->master  result fraction, hidden bit dropped
interface fp_mul_seq_if;
  logic        start;
  logic [31:0] A_FP;
  logic [31:0] B_FP;
  logic        busy;
  logic        done;
  logic        sign;
  logic [7:0]  exponent;
  logic [22:0] mantissa;

  modport master (
    output start, A_FP, B_FP,
    input  busy, done, sign, exponent, mantissa
  );

  modport slave (
    input  start, A_FP, B_FP,
    output busy, done, sign, exponent, mantissa
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier feeding the fp_add
// accumulate stage. The 24x24 mantissa product is built by a shift-add loop
// that retires BITS_PER_CYCLE multiplier bits per edge. The result is
// truncated, not rounded, and is returned as separate sign/exponent/mantissa
// fields. Denormal inputs flush to zero, and NaN/Inf inputs give an infinity
// pattern.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        fp_mul_seq_if.slave: start/A_FP/B_FP in, busy/done/result out
//   dbg_state  current FSM state (0=IDLE, 1=MUL, 2=NORM)
//
// Timing: start is accepted at edge 0, and done is high after edge N+1,
// where N = 24/BITS_PER_CYCLE. This latency does not depend on the operands.
module fp_mul_seq #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int BIAS           = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus,
  output logic [1:0]   dbg_state
);

  localparam int K = BITS_PER_CYCLE;
  localparam int N = 24 / BITS_PER_CYCLE;

  // Only divisors of 24 give a whole number of iterations.
  generate
    if (K < 1 || K > 24 || (24 % K) != 0) begin : g_bad_bits_per_cycle
      $error("fp_mul_seq: BITS_PER_CYCLE must divide 24");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [4:0]   cnt;
  logic [47:0]  mcand;
  logic [23:0]  mplier;
  logic [47:0]  p;
  logic         s_a, s_b;
  logic [7:0]   e_a, e_b;

  logic [47:0]        partial;
  logic signed [9:0]  e_sum;
  logic [7:0]         res_exp;
  logic [22:0]        res_mant;
  logic               unused_p_low;

  assign dbg_state = state;

  // The truncated fraction never uses the low product bits.
  assign unused_p_low = ^p[22:0];

  // Sum of the multiplicand shifted by each set bit in the low K multiplier
  // bits. The multiplicand is already aligned to this iteration's weight.
  always_comb begin
    partial = '0;
    for (int i = 0; i < K; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  // Result packing. A product in [2,4) has P[47] set and takes one extra
  // exponent step. The 10-bit signed sum cannot wrap, because the operand
  // exponents are at most 254 here.
  always_comb begin
    e_sum    = 10'({2'b00, e_a} + {2'b00, e_b} - 10'(BIAS) + {9'd0, p[47]});
    res_exp  = e_sum[7:0];
    res_mant = p[47] ? p[46:24] : p[45:23];
    if (e_a == 8'd0 || e_b == 8'd0) begin
      res_exp  = 8'd0;
      res_mant = '0;
    end else if (e_a == 8'hff || e_b == 8'hff) begin
      res_exp  = 8'hff;
      res_mant = '0;
    end else if (e_sum <= 10'sd0) begin
      res_exp  = 8'd0;
      res_mant = '0;
    end else if (e_sum >= 10'sd255) begin
      res_exp  = 8'hff;
      res_mant = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     if (cnt == 5'(N - 1)) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      p            <= '0;
      s_a          <= 1'b0;
      s_b          <= 1'b0;
      e_a          <= '0;
      e_b          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sign     <= 1'b0;
      bus.exponent <= '0;
      bus.mantissa <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            s_a      <= bus.A_FP[31];
            s_b      <= bus.B_FP[31];
            e_a      <= bus.A_FP[30:23];
            e_b      <= bus.B_FP[30:23];
            mcand    <= {24'd0, 1'b1, bus.A_FP[22:0]};
            mplier   <= {1'b1, bus.B_FP[22:0]};
            p        <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        MUL: begin
          p      <= p + partial;
          mcand  <= mcand << K;
          mplier <= mplier >> K;
          cnt    <= cnt + 5'd1;
        end
        NORM: begin
          bus.sign     <= s_a ^ s_b;
          bus.exponent <= res_exp;
          bus.mantissa <= res_mant;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs: BITS_PER_CYCLE = 1, 4, 24 ----------------
  fp_mul_seq_if if0();
  fp_mul_seq_if if1();
  fp_mul_seq_if if2();

  logic [2:0]  start_v = '0;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  logic [31:0] res_v [3];
  logic [1:0]  dbg0, dbg1, dbg2;

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.A_FP = a_v[0];
  assign if1.A_FP = a_v[1];
  assign if2.A_FP = a_v[2];
  assign if0.B_FP = b_v[0];
  assign if1.B_FP = b_v[1];
  assign if2.B_FP = b_v[2];
  assign done_v = {if2.done, if1.done, if0.done};
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign res_v[0] = {if0.sign, if0.exponent, if0.mantissa};
  assign res_v[1] = {if1.sign, if1.exponent, if1.mantissa};
  assign res_v[2] = {if2.sign, if2.exponent, if2.mantissa};

  fp_mul_seq #(.BITS_PER_CYCLE(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state(dbg0));
  fp_mul_seq #(.BITS_PER_CYCLE(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state(dbg1));
  fp_mul_seq #(.BITS_PER_CYCLE(24)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .dbg_state(dbg2));

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 24;
      1:       return 6;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Real-valued reasoning on integers: product of the two 1.f significands,
  // then scale into [1,2), then apply the special-case order.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, prod, frac;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0)     return {s, 31'd0};
    if (ea == 255 || eb == 255) return {s, 8'hff, 23'd0};
    ma   = longint'({1'b1, a[22:0]});
    mb   = longint'({1'b1, b[22:0]});
    prod = ma * mb;                        // value = prod * 2^-46
    e    = ea + eb - 127;
    if (prod >= (longint'(1) << 47)) begin
      e    = e + 1;
      frac = (prod >> 24) % (longint'(1) << 23);
    end else begin
      frac = (prod >> 23) % (longint'(1) << 23);
    end
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, 8'(e), 23'(frac)};
  endfunction

  // ---------------- scoreboard ----------------
  // entry: {instance[1:0], expected cyc at done negedge[31:0], result[31:0]}
  localparam int W = 66;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: instance %0d got done, expected none", i);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("done_instance", 64'(i), 64'(e[65:64]));
            chk("done_edge", 64'(cyc), 64'(e[63:32]));
            chk("result", 64'(res_v[i]), 64'(e[31:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input bit wait_neg);
    if (wait_neg) @(negedge clk);
    a_v[idx] = a;
    b_v[idx] = b;
    start_v[idx] = 1'b1;
    exp_q.push_back({2'(idx), 32'(cyc + n_of(idx) + 2), model(a, b)});
    @(negedge clk);
    start_v[idx] = 1'b0;
    // Operands change after acceptance; the result in flight must not care.
    a_v[idx] = $urandom;
    b_v[idx] = $urandom;
  endtask

  task automatic wait_done(input int idx);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done_v[idx]) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: instance %0d got no done, expected one", idx);
    end
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] tab_a   [6] = '{32'h00000000, 32'h80000000, 32'h007FFFFF,
                               32'h7F000000, 32'h00800000, 32'h7F800000};
  logic [31:0] tab_b   [6] = '{32'h42F60000, 32'h3F800000, 32'h3F800000,
                               32'h40000000, 32'h3F000000, 32'h3F800000};
  logic [31:0] tab_exp [6] = '{32'h00000000, 32'h80000000, 32'h00000000,
                               32'h7F800000, 32'h00000000, 32'h7F800000};

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 64'(busy_v[i]), 64'd0);
      chk("reset_done", 64'(done_v[i]), 64'd0);
      chk("reset_result", 64'(res_v[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Pin the model to hand-computed values.
    chk("model_2x3", 64'(model(32'h40000000, 32'h40400000)), 64'h40C00000);
    chk("model_1p5xm1p5", 64'(model(32'h3FC00000, 32'hBFC00000)), 64'hC0100000);
    chk("model_ovf", 64'(model(32'h7F000000, 32'h40000000)), 64'h7F800000);

    // 2.0 x 3.0, busy high from edge 0 through edge 24, done after edge 25.
    start_op(0, 32'h40000000, 32'h40400000, 1);
    for (int e = 0; e < 25; e++) begin
      chk("busy_window", 64'(busy_v[0]), 64'd1);
      chk("no_early_done", 64'(done_v[0]), 64'd0);
      @(negedge clk);
    end
    chk("done_at_25", 64'(done_v[0]), 64'd1);
    chk("busy_off_at_done", 64'(busy_v[0]), 64'd0);
    chk("lit_2x3", 64'(res_v[0]), 64'h40C00000);
    @(negedge clk);
    chk("done_pulse_drop", 64'(done_v[0]), 64'd0);
    chk("result_hold", 64'(res_v[0]), 64'h40C00000);

    // 1.5 x -1.5, P[47]=1 path.
    start_op(0, 32'h3FC00000, 32'hBFC00000, 1);
    wait_done(0);
    chk("lit_1p5xm1p5", 64'(res_v[0]), 64'hC0100000);

    // Zero, denormal, overflow, underflow, infinity.
    for (int t = 0; t < 6; t++) begin
      start_op(0, tab_a[t], tab_b[t], 1);
      wait_done(0);
      chk("lit_special", 64'(res_v[0]), 64'(tab_exp[t]));
    end

    // start re-pulsed at edge 5 while busy: ignored.
    start_op(0, 32'h40000000, 32'h40400000, 1);
    repeat (4) @(negedge clk);
    a_v[0] = 32'h3FC00000;
    b_v[0] = 32'hBFC00000;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    chk("lit_ignored_start", 64'(res_v[0]), 64'h40C00000);
    repeat (30) @(negedge clk);

    // start held on the done cycle: accepted back to back.
    start_op(0, 32'h40000000, 32'h40400000, 1);
    wait_done(0);
    chk("lit_b2b_first", 64'(res_v[0]), 64'h40C00000);
    start_op(0, 32'h3FC00000, 32'hBFC00000, 0);
    wait_done(0);
    chk("lit_b2b_second", 64'(res_v[0]), 64'hC0100000);

    // Reset at edge 10 aborts the operation.
    start_op(0, 32'h40000000, 32'h40400000, 1);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_done", 64'(done_v[0]), 64'd0);
    chk("abort_result", 64'(res_v[0]), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      bit seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done_v[0]) seen = 1;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
    end
    start_op(0, 32'h3FC00000, 32'hBFC00000, 1);
    wait_done(0);
    chk("lit_after_abort", 64'(res_v[0]), 64'hC0100000);

    // Wider iteration steps: same results, done after edges 7 and 2.
    for (int idx = 1; idx < 3; idx++) begin
      start_op(idx, 32'h40000000, 32'h40400000, 1);
      wait_done(idx);
      chk("lit_wide_2x3", 64'(res_v[idx]), 64'h40C00000);
      start_op(idx, 32'h3FC00000, 32'hBFC00000, 1);
      wait_done(idx);
      chk("lit_wide_1p5xm1p5", 64'(res_v[idx]), 64'hC0100000);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
